cv32e40p_alu_fault_monitor: RTL and testbench

- Classifies ALU replicas as transient-faulty or permanent-faulty from per-replica voter mismatches.
- Sequences the switch-over handshake with the pipeline controller.
- Its registered permanent-fault vector is the sole driver of the replica-selection decoder input (which ALUs are clock-gated and which EX result mux is used).
- Sits beside the EX-stage TMR voter.

---
 rtl/cv32e40p_fault_pkg.sv | 20 ++
 rtl/cv32e40p_alu_err_counter.sv | 42 ++++
 rtl/cv32e40p_alu_fault_monitor.sv | 135 +++++++++++++
 tb/tb_cv32e40p_alu_fault_monitor.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_fault_pkg.sv
// Shared types and defaults for the ALU fault monitor.
// The optional ALU_FAULT_STATS_EN build uses STATS_W and stats_inc.
package cv32e40p_fault_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_COMMIT = 2'd2
    } fault_state_e;

    localparam int DEF_CNT_W        = 4;
    localparam int DEF_THRESHOLD    = 8;
    localparam int DEF_DECAY_WINDOW = 16;
    localparam int STATS_W          = 16;

    function automatic logic [STATS_W-1:0] stats_inc(input logic [STATS_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cv32e40p_alu_err_counter.sv
// Per-replica saturating error counter with decay and a threshold compare
// that raises the pending set-request on the crossing edge.
module cv32e40p_alu_err_counter
    import cv32e40p_fault_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int THRESHOLD = DEF_THRESHOLD
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic err_i,
    input  logic decay_i,
    output logic set_pend_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESHOLD);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (err_i) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end else if (decay_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Only an increment can cross upward, so frozen counters sitting at or
    // above threshold never re-request.
    assign set_pend_o = err_i && (cnt_d >= THR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          cnt_q <= '0;
        else if (clear_i) cnt_q <= '0;
        else              cnt_q <= cnt_d;
    end

endmodule

// File: rtl/cv32e40p_alu_fault_monitor.sv
// Classifies ALU replicas as transient/permanent faulty and sequences the
// drain/switch-over handshake. Optional stats counters: ALU_FAULT_STATS_EN.
//
// state  | meaning
// IDLE   | no switch-over in progress
// REQ    | pending faults waiting for pipeline drain ack
// COMMIT | pending folded into permanent, one cycle
module cv32e40p_alu_fault_monitor
    import cv32e40p_fault_pkg::*;
#(
    parameter int N_ALU        = 4,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int THRESHOLD    = DEF_THRESHOLD,
    parameter int DECAY_WINDOW = DEF_DECAY_WINDOW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             valid_i,
    input  logic [N_ALU-1:0] active_alu_i,
    input  logic [N_ALU-1:0] mismatch_i,
    output logic             reconfig_req_o,
    input  logic             reconfig_ack_i,
    output logic [N_ALU-1:0] permanent_faulty_alu_o,
    output logic [N_ALU-1:0] fault_pending_o,
    output logic             monitor_busy_o
`ifdef ALU_FAULT_STATS_EN
    ,
    output logic [N_ALU*STATS_W-1:0] err_total_o
`endif
);

    localparam int               WIN_W   = (DECAY_WINDOW > 2) ? $clog2(DECAY_WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_MAX = WIN_W'(DECAY_WINDOW - 1);

    if ((THRESHOLD < 1) || (THRESHOLD > (2**CNT_W) - 1)) begin : g_bad_threshold
        $error("THRESHOLD must lie in 1 .. 2**CNT_W-1");
    end
    if ((DECAY_WINDOW < 2) || ((DECAY_WINDOW & (DECAY_WINDOW - 1)) != 0)) begin : g_bad_window
        $error("DECAY_WINDOW must be a power of two >= 2");
    end

    fault_state_e     state_q, state_d;
    logic [N_ALU-1:0] perm_q, pend_q;
    logic [N_ALU-1:0] eligible, err_ev, set_pend;
    logic [WIN_W-1:0] win_q, win_d;
    logic             any_err, clean, decay_tick, commit;
    logic             req_q, busy_q;

    assign eligible   = active_alu_i & ~perm_q & ~pend_q;
    assign err_ev     = {N_ALU{valid_i}} & eligible & mismatch_i;
    assign any_err    = |err_ev;
    assign clean      = valid_i && !any_err;
    assign decay_tick = clean && (win_q == WIN_MAX);

    always_comb begin
        win_d = win_q;
        if (any_err)         win_d = '0;
        else if (decay_tick) win_d = '0;
        else if (clean)      win_d = win_q + 1'b1;
    end

    for (genvar i = 0; i < N_ALU; i++) begin : g_cnt
        cv32e40p_alu_err_counter #(
            .CNT_W     (CNT_W),
            .THRESHOLD (THRESHOLD)
        ) u_cnt (
            .clk        (clk),
            .rst        (rst),
            .clear_i    (clear_i),
            .err_i      (err_ev[i]),
            .decay_i    (decay_tick && eligible[i]),
            .set_pend_o (set_pend[i])
        );
    end

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE:   if (|pend_q) state_d = ST_REQ;
            ST_REQ:    if (reconfig_ack_i) begin
                           state_d = ST_COMMIT;
                           commit  = 1'b1;
                       end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // A crossing on the ack edge itself stays pending and triggers a
    // back-to-back request after COMMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            perm_q  <= '0;
            pend_q  <= '0;
            win_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else if (clear_i) begin
            state_q <= ST_IDLE;
            perm_q  <= '0;
            pend_q  <= '0;
            win_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            perm_q  <= commit ? (perm_q | pend_q) : perm_q;
            pend_q  <= (commit ? '0 : pend_q) | set_pend;
            win_q   <= win_d;
            req_q   <= (state_d == ST_REQ);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign reconfig_req_o         = req_q;
    assign monitor_busy_o         = busy_q;
    assign permanent_faulty_alu_o = perm_q;
    assign fault_pending_o        = pend_q;

`ifdef ALU_FAULT_STATS_EN
    for (genvar i = 0; i < N_ALU; i++) begin : g_stats
        logic [STATS_W-1:0] tot_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)            tot_q <= '0;
            else if (clear_i)   tot_q <= '0;
            else if (err_ev[i]) tot_q <= stats_inc(tot_q);
        end
        assign err_total_o[i*STATS_W +: STATS_W] = tot_q;
    end
`endif

endmodule

// File: tb/tb_cv32e40p_alu_fault_monitor.sv
// Directed and randomized bench for cv32e40p_alu_fault_monitor against a
// behavioural model of the fault-classification rules.
module tb_cv32e40p_alu_fault_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear_i;
    logic        valid_i;
    logic [3:0]  active_alu_i;
    logic [3:0]  mismatch_i;
    logic        reconfig_req_o;
    logic        reconfig_ack_i;
    logic [3:0]  permanent_faulty_alu_o;
    logic [3:0]  fault_pending_o;
    logic        monitor_busy_o;
`ifdef ALU_FAULT_STATS_EN
    logic [63:0] err_total_o;
`endif

    cv32e40p_alu_fault_monitor dut (
        .clk                    (clk),
        .rst                    (rst),
        .clear_i                (clear_i),
        .valid_i                (valid_i),
        .active_alu_i           (active_alu_i),
        .mismatch_i             (mismatch_i),
        .reconfig_req_o         (reconfig_req_o),
        .reconfig_ack_i         (reconfig_ack_i),
        .permanent_faulty_alu_o (permanent_faulty_alu_o),
        .fault_pending_o        (fault_pending_o),
        .monitor_busy_o         (monitor_busy_o)
`ifdef ALU_FAULT_STATS_EN
        ,
        .err_total_o            (err_total_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain integers per replica, handshake as a phase number
    int         m_cnt[4];
    int         m_tot[4];
    logic [3:0] m_pend;
    logic [3:0] m_perm;
    int         m_win;
    int         m_phase;   // 0 idle, 1 requesting, 2 committing
    int         req_rises;
    logic       req_prev;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0;
            m_tot[i] = 0;
        end
        m_pend  = '0;
        m_perm  = '0;
        m_win   = 0;
        m_phase = 0;
    endtask

    task automatic model_step();
        logic [3:0] elig;
        logic [3:0] newp;
        bit         anyerr;
        bit         had_pend;
        if (clear_i) begin
            model_reset();
            return;
        end
        newp   = '0;
        anyerr = 0;
        for (int i = 0; i < 4; i++) begin
            elig[i] = active_alu_i[i] && !m_perm[i] && !m_pend[i];
            if (valid_i && elig[i] && mismatch_i[i]) begin
                anyerr = 1;
                if (m_cnt[i] < 15) m_cnt[i]++;
                if (m_cnt[i] >= 8) newp[i] = 1'b1;
                if (m_tot[i] < 65535) m_tot[i]++;
            end
        end
        if (valid_i) begin
            if (anyerr) m_win = 0;
            else if (m_win == 15) begin
                m_win = 0;
                for (int i = 0; i < 4; i++)
                    if (elig[i] && m_cnt[i] > 0) m_cnt[i]--;
            end else m_win++;
        end
        had_pend = (m_pend != 0);
        if (m_phase == 1 && reconfig_ack_i) begin
            m_perm  = m_perm | m_pend;
            m_pend  = newp;
            m_phase = 2;
        end else begin
            m_pend = m_pend | newp;
            if (m_phase == 2) m_phase = 0;
            else if (m_phase == 0 && had_pend) m_phase = 1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("pending", 16'(fault_pending_o), 16'(m_pend));
        chk("permanent", 16'(permanent_faulty_alu_o), 16'(m_perm));
        chk("req", 16'(reconfig_req_o), 16'(m_phase == 1));
        chk("busy", 16'(monitor_busy_o), 16'(m_phase != 0));
`ifdef ALU_FAULT_STATS_EN
        for (int i = 0; i < 4; i++)
            chk("err_total", err_total_o[i*16 +: 16], 16'(m_tot[i]));
`endif
        if (reconfig_req_o && !req_prev) req_rises++;
        req_prev = reconfig_req_o;
    endtask

    task automatic drive(input logic v, input logic [3:0] act, input logic [3:0] mm,
                         input logic ack, input logic clr);
        valid_i        = v;
        active_alu_i   = act;
        mismatch_i     = mm;
        reconfig_ack_i = ack;
        clear_i        = clr;
    endtask

    task automatic run(input int n, input logic v, input logic [3:0] act, input logic [3:0] mm);
        for (int k = 0; k < n; k++) begin
            drive(v, act, mm, 1'b0, 1'b0);
            cycle();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 16'({fault_pending_o, permanent_faulty_alu_o, reconfig_req_o, monitor_busy_o}), 16'h0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        model_reset();
        req_prev  = 1'b0;
        req_rises = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset_outputs");
`ifdef ALU_FAULT_STATS_EN
        chk("reset_stats", err_total_o[15:0] | err_total_o[31:16] | err_total_o[47:32] | err_total_o[63:48], 16'h0);
`endif
        rst = 1'b0;

        // idle traffic, never a mismatch
        for (int k = 0; k < 100; k++) begin
            drive(1'(k % 2), 4'hF, 4'h0, 1'b0, 1'b0);
            cycle();
        end
        chk_all_zero("idle_100");

        // ALU1 crosses after 8 mismatches
        run(8, 1'b1, 4'b0111, 4'b0010);
        chk("alu1_pending", 16'(fault_pending_o), 16'h2);
        chk("alu1_req_not_yet", 16'(reconfig_req_o), 16'h0);
        run(1, 1'b0, 4'b0111, 4'b0000);
        chk("alu1_req", 16'(reconfig_req_o), 16'h1);
        run(2, 1'b0, 4'b0111, 4'b0000);
        drive(1'b0, 4'b0111, 4'b0000, 1'b1, 1'b0);
        cycle();
        chk("alu1_perm", 16'({permanent_faulty_alu_o, fault_pending_o}), 16'h20);
        chk("alu1_commit", 16'({reconfig_req_o, monitor_busy_o}), 16'h1);
        run(1, 1'b0, 4'b0111, 4'b0000);
        chk("alu1_idle", 16'(monitor_busy_o), 16'h0);

        // decay: 5 errors, two decay windows, then 5 more errors
        run(5, 1'b1, 4'b0001, 4'b0001);
        run(32, 1'b1, 4'b0001, 4'b0000);
        run(3, 1'b1, 4'b0001, 4'b0001);
        chk("decay_cnt6", 16'(fault_pending_o), 16'h0);
        run(1, 1'b1, 4'b0001, 4'b0001);
        chk("decay_cnt7", 16'(fault_pending_o), 16'h0);
        run(1, 1'b1, 4'b0001, 4'b0001);
        chk("decay_cross", 16'(fault_pending_o), 16'h1);
        drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        cycle();
        chk_all_zero("clear_after_decay");

        // simultaneous crossing on ALU0 and ALU2
        run(7, 1'b1, 4'b0101, 4'b0101);
        chk("simul_pre", 16'(fault_pending_o), 16'h0);
        run(1, 1'b1, 4'b0101, 4'b0101);
        chk("simul_pending", 16'(fault_pending_o), 16'h5);
        run(1, 1'b0, 4'b0101, 4'b0000);
        drive(1'b0, 4'b0101, 4'b0000, 1'b1, 1'b0);
        cycle();
        chk("simul_perm", 16'(permanent_faulty_alu_o), 16'h5);
        run(1, 1'b0, 4'b0101, 4'b0000);
        drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        cycle();

        // ALU2 crosses while the ALU1 request is outstanding
        req_rises = 0;
        run(7, 1'b1, 4'b0110, 4'b0110);
        run(1, 1'b1, 4'b0110, 4'b0010);
        chk("req_alu1_pending", 16'(fault_pending_o), 16'h2);
        run(1, 1'b1, 4'b0110, 4'b0100);
        chk("req_both_pending", 16'({fault_pending_o, 3'b000, reconfig_req_o}), 16'h61);
        run(3, 1'b0, 4'b0110, 4'b0000);
        drive(1'b0, 4'b0110, 4'b0000, 1'b1, 1'b0);
        cycle();
        chk("req_perm", 16'({permanent_faulty_alu_o, fault_pending_o}), 16'h60);
        run(2, 1'b0, 4'b0110, 4'b0000);
        chk("req_single_assert", 16'(req_rises), 16'h1);

        // clear drops an in-flight request
        run(8, 1'b1, 4'b0001, 4'b0001);
        run(1, 1'b0, 4'b0001, 4'b0000);
        chk("clr_req_up", 16'(reconfig_req_o), 16'h1);
        drive(1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1);
        cycle();
        chk_all_zero("clr_in_req");

`ifdef ALU_FAULT_STATS_EN
        for (int k = 0; k < 20; k++) begin
            run(1, 1'b1, 4'b1000, 4'b1000);
            run(16, 1'b1, 4'b1000, 4'b0000);
        end
        chk("stats_alu3", err_total_o[63:48], 16'd20);
        chk("stats_no_pend", 16'(fault_pending_o), 16'h0);
`endif

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            logic [3:0] mm;
            for (int i = 0; i < 4; i++) mm[i] = ($urandom_range(0, 5) == 0);
            drive(1'($urandom_range(0, 9) < 7),
                  4'($urandom_range(0, 15)) | 4'b0001,
                  mm,
                  1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 299) == 0));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
